// File: rtl/dmem_mmio_responder_if.sv
// Data-memory port bundle between the CPU and the dmem/MMIO responder.
// It also carries the TX byte stream that drains to the downstream serializer.
//   daddr    32  byte address (bits [1:0] ignored)
//   dwdata   32  lane-aligned write data
//   dwe       4  per-byte write enables, 0 = read only
//   drdata   32  combinational read data
//   tx_data   8  FIFO head byte, 0 when empty
//   tx_valid  1  FIFO non-empty
//   tx_ready  1  downstream accepts head at posedge
interface dmem_mmio_responder_if;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // CPU / downstream side
  modport master (
    output daddr, dwdata, dwe, tx_ready,
    input  drdata, tx_data, tx_valid
  );

  // responder side
  modport slave (
    input  daddr, dwdata, dwe, tx_ready,
    output drdata, tx_data, tx_valid
  );
endinterface

// File: rtl/dmem_mmio_responder.sv
// Responder for the single-cycle CPU data-memory port.
// Serves a byte-writable RAM (daddr[31]==0) and an MMIO block (daddr[31]==1):
// a TX byte FIFO, a sticky status register and a free-running cycle counter.
// Loads are combinational; stores commit on posedge clk.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    dmem_mmio_responder_if.slave (CPU data port + TX stream)
module dmem_mmio_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input logic                  clk,
  input logic                  reset,
  dmem_mmio_responder_if.slave bus
);

  localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = FIFO_AW + 1;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CYCLE  = 2'd2;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic              mmio_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        mmio_off;
  logic              wr_en;

  assign mmio_sel = (bus.daddr[31] == MMIO_BASE[31]);
  assign ram_idx  = bus.daddr[RAM_AW+1:2];
  assign mmio_off = bus.daddr[3:2];
  assign wr_en    = !reset && (bus.dwe != 4'h0);

  // Upper address bits alias into the RAM; they are deliberately not decoded.
  logic unused_addr;
  assign unused_addr = ^bus.daddr;

  // ---------------------------------------------------------------------------
  // RAM: byte-lane writes, no reset of contents
  // ---------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];
  logic        ram_we;

  assign ram_we = wr_en && !mmio_sel;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && bus.dwe[i]) begin
        ram[ram_idx][8*i +: 8] <= bus.dwdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO control
  // ---------------------------------------------------------------------------
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] head;
  logic [FIFO_AW-1:0] tail;
  logic [CNT_W-1:0]   count;
  logic               ovf;
  logic               empty;
  logic               full;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               ovf_set;
  logic               ovf_clr;

  assign empty = (count == CNT_W'(0));
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  // Pop is gated by reset so a drain handshake during reset is not counted.
  assign pop      = !reset && !empty && bus.tx_ready;
  assign push_req = wr_en && mmio_sel && (mmio_off == OFF_TXDATA) && bus.dwe[0];
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = wr_en && mmio_sel && (mmio_off == OFF_STATUS) && bus.dwdata[2];

  // FIFO storage, not reset; only entries between head and tail are meaningful
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= bus.dwdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) begin
        tail <= FIFO_AW'(tail + 1'b1);
      end
      if (pop) begin
        head <= FIFO_AW'(head + 1'b1);
      end
      case ({push, pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = empty ? 8'h00 : fifo_mem[head];

  // ---------------------------------------------------------------------------
  // Free-running cycle counter; a full-word store overrides the increment
  // ---------------------------------------------------------------------------
  logic [31:0] cycle;
  logic        cycle_load;

  assign cycle_load = wr_en && mmio_sel && (mmio_off == OFF_CYCLE) && (bus.dwe == 4'hF);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
    end else if (cycle_load) begin
      cycle <= bus.dwdata;
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read mux
  // ---------------------------------------------------------------------------
  logic [7:0] count_ext;

  assign count_ext = 8'(count);

  always_comb begin
    bus.drdata = 32'h0;
    if (!mmio_sel) begin
      bus.drdata = ram[ram_idx];
    end else begin
      case (mmio_off)
        OFF_STATUS: bus.drdata = {16'h0, count_ext, 5'b0, ovf, empty, full};
        OFF_CYCLE:  bus.drdata = cycle;
        default:    bus.drdata = 32'h0;
      endcase
    end
  end

endmodule
